// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues single-outstanding imem reads,
// buffers returned words in a small FIFO for decode. Optional counters under FETCH_PERF_EN.
module instr_fetch_unit #(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [31:0] dec_instr,
   output logic [31:0] dec_pc,
   output logic [5:0]  dec_opcode,
   output logic [5:0]  dec_funct,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall
);

   localparam int          PW      = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

   state_t         state_q, state_d;
   logic [31:0]    fetch_pc_q, fetch_pc_d;
   logic [31:0]    imem_addr_q, imem_addr_d;
   logic [31:0]    instr_mem_q [DEPTH];
   logic [31:0]    pc_mem_q [DEPTH];
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]    count_q, count_d, count_after;
   logic           push, pop;
   logic [31:0]    redirect_al;

   assign redirect_al = redirect_pc & 32'hFFFF_FFFC;
   assign pop         = (count_q != '0) && dec_ready;
   // Occupancy once the response in flight lands, net of any same-cycle pop.
   assign count_after = count_q + {{PW{1'b0}}, 1'b1} - {{PW{1'b0}}, pop};

   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      imem_addr_d = imem_addr_q;
      push        = 1'b0;
      case (state_q)
         IDLE: begin
            if (redirect) begin
               state_d     = REQ;
               fetch_pc_d  = redirect_al;
               imem_addr_d = redirect_al;
            end else if (count_q < DEPTH_C) begin
               state_d     = REQ;
               imem_addr_d = fetch_pc_q;
            end
         end
         REQ: begin
            if (imem_gnt) begin
               state_d    = redirect ? DROP : WAIT;
               fetch_pc_d = redirect ? redirect_al : fetch_pc_q + 32'd4;
            end else if (redirect) begin
               fetch_pc_d  = redirect_al;
               imem_addr_d = redirect_al;
            end
         end
         WAIT: begin
            if (redirect) begin
               fetch_pc_d = redirect_al;
               if (imem_rvalid) begin
                  state_d     = REQ;
                  imem_addr_d = redirect_al;
               end else begin
                  state_d = DROP;
               end
            end else if (imem_rvalid) begin
               push = 1'b1;
               if (count_after < DEPTH_C) begin
                  state_d     = REQ;
                  imem_addr_d = fetch_pc_q;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DROP: begin
            if (redirect) fetch_pc_d = redirect_al;
            if (imem_rvalid) begin
               state_d     = REQ;
               imem_addr_d = redirect ? redirect_al : fetch_pc_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, push};
      rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, pop};
      count_d  = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      if (redirect) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         fetch_pc_q  <= RESET_PC;
         imem_addr_q <= RESET_PC;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         imem_addr_q <= imem_addr_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   // The word's own fetch address is still held in imem_addr_q while waiting.
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         instr_mem_q[wr_ptr_q] <= imem_rdata;
         pc_mem_q[wr_ptr_q]    <= imem_addr_q;
      end
   end

   assign imem_req   = (state_q == REQ);
   assign imem_addr  = imem_addr_q;
   assign dec_valid  = (count_q != '0);
   assign dec_instr  = instr_mem_q[rd_ptr_q];
   assign dec_pc     = pc_mem_q[rd_ptr_q];
   assign dec_opcode = dec_instr[31:26];
   assign dec_funct  = dec_instr[5:0];

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched_q, perf_fetched_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   always_comb begin
      perf_fetched_d = perf_fetched_q + {31'b0, push};
      perf_stall_d   = perf_stall_q + {31'b0, dec_ready && (count_q == '0)};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetched_q <= '0;
         perf_stall_q   <= '0;
      end else begin
         perf_fetched_q <= perf_fetched_d;
         perf_stall_q   <= perf_stall_d;
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_stall   = perf_stall_q;
`else
   assign perf_fetched = 32'd0;
   assign perf_stall   = 32'd0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a program-order PC model predicts every decode transfer
// while a randomised single-outstanding memory responds to fetches.
module tb_instr_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;
   logic [5:0]  dec_opcode;
   logic [5:0]  dec_funct;
   logic [31:0] perf_fetched;
   logic [31:0] perf_stall;

   instr_fetch_unit #(.DEPTH(2), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
      .dec_pc(dec_pc), .dec_opcode(dec_opcode), .dec_funct(dec_funct),
      .perf_fetched(perf_fetched), .perf_stall(perf_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_cmp  = 0;
   int          n_bad  = 0;
   int          n_xfer = 0;
   logic [31:0] exp_pc;
   logic [31:0] exp_instr;

   // Memory model knobs and state
   int          gnt_pct = 100;
   int          dly_min = 0;
   int          dly_max = 0;
   int          budget  = -1;
   logic [31:0] gnt_log[$];
   bit          pend = 1'b0;
   logic [31:0] pend_addr;
   int          pend_dly;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0000_0020;
      return {~a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] log_at(input int i);
      if (i < gnt_log.size()) return gnt_log[i];
      return 32'hDEAD_DEAD;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Memory: one outstanding read, data 1+dly cycles after gnt.
   initial begin
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      forever begin
         @(negedge clk);
         imem_gnt    = 1'b0;
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
         if (pend) begin
            if (pend_dly == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = mem_word(pend_addr);
               pend        = 1'b0;
            end else begin
               pend_dly--;
            end
         end else if (imem_req && budget != 0 &&
                      int'($urandom_range(100, 1)) <= gnt_pct) begin
            imem_gnt  = 1'b1;
            pend      = 1'b1;
            pend_addr = imem_addr;
            pend_dly  = int'($urandom_range(dly_max, dly_min));
            gnt_log.push_back(imem_addr);
            if (budget > 0) budget--;
         end
      end
   end

   // One clock cycle: drive inputs at negedge, then check any transfer against the model.
   // rdy_mode 2 means ready mirrors dec_valid (never starves).
   task automatic cycle(input bit rst, input int rdy_mode, input bit redir, input logic [31:0] rpc);
      @(negedge clk);
      reset       = rst;
      dec_ready   = (rdy_mode == 2) ? dec_valid : (rdy_mode != 0);
      redirect    = redir;
      redirect_pc = rpc;
      #1;
      if (rst) begin
         exp_pc = RESET_PC;
      end else begin
         if (dec_valid && dec_ready) begin
            exp_instr = mem_word(exp_pc);
            chk("dec_pc", dec_pc, exp_pc);
            chk("dec_instr", dec_instr, exp_instr);
            chk("dec_opcode", {26'b0, dec_opcode}, {26'b0, exp_instr[31:26]});
            chk("dec_funct", {26'b0, dec_funct}, {26'b0, exp_instr[5:0]});
            $display("xfer pc=%h instr=%h", dec_pc, dec_instr);
            exp_pc = exp_pc + 32'd4;
            n_xfer++;
         end
         if (redir) exp_pc = rpc & 32'hFFFF_FFFC;
      end
   endtask

   task automatic do_reset();
      for (int i = 0; i < 6; i++) cycle(1'b1, 0, 1'b0, 32'h0);
      gnt_log.delete();
   endtask

   task automatic wait_xfers(input int n, input int bound, input string tag);
      int base;
      int t;
      base = n_xfer;
      t    = 0;
      while ((n_xfer - base) < n && t < bound) begin
         cycle(1'b0, 1, 1'b0, 32'h0);
         t++;
      end
      chk(tag, 32'((n_xfer - base) >= n), 32'd1);
   endtask

   task automatic wait_grant(input int bound, input string tag);
      int s;
      int t;
      s = gnt_log.size();
      t = 0;
      while (gnt_log.size() == s && t < bound) begin
         cycle(1'b0, 1, 1'b0, 32'h0);
         t++;
      end
      chk(tag, 32'(gnt_log.size() > s), 32'd1);
   endtask

   initial begin
      int s;
      reset       = 1'b1;
      dec_ready   = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      exp_pc      = RESET_PC;

      // Reset state
      do_reset();
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      chk("rst_dec_valid", 32'(dec_valid), 32'd0);
      chk("rst_imem_addr", imem_addr, RESET_PC);
      chk("rst_perf_fetched", perf_fetched, 32'd0);
      chk("rst_perf_stall", perf_stall, 32'd0);

      // Basic streaming: gnt immediate, data one cycle later
      cycle(1'b0, 1, 1'b0, 32'h0);
      chk("idle_no_req", 32'(imem_req), 32'd0);
      cycle(1'b0, 1, 1'b0, 32'h0);
      chk("first_req", 32'(imem_req), 32'd1);
      chk("first_addr", imem_addr, RESET_PC);
      wait_xfers(3, 40, "stream_timeout");
      chk("stream_addr0", log_at(0), 32'h0);
      chk("stream_addr1", log_at(1), 32'h4);
      chk("stream_addr2", log_at(2), 32'h8);

      // Backpressure: only DEPTH words fetched, head held stable
      do_reset();
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 0, 1'b0, 32'h0);
         if (i >= 6) begin
            chk("full_no_req", 32'(imem_req), 32'd0);
            chk("full_valid", 32'(dec_valid), 32'd1);
            chk("full_hold_pc", dec_pc, 32'h0);
            chk("full_hold_instr", dec_instr, 32'h0000_0020);
         end
      end
      chk("full_pushes", 32'(gnt_log.size()), 32'd2);
      wait_xfers(3, 40, "drain_timeout");
      chk("resume_addr", log_at(2), 32'h8);

      // Redirect while waiting on 0x8: response dropped, fetch resumes at 0x100
      do_reset();
      dly_min = 4;
      dly_max = 4;
      while (gnt_log.size() < 3 && n_cmp < 1000000) begin
         cycle(1'b0, 1, 1'b0, 32'h0);
         if (gnt_log.size() == 0 && exp_pc > 32'h40) break;
      end
      chk("grant_of_8", log_at(2), 32'h8);
      cycle(1'b0, 1, 1'b1, 32'h0000_0103);
      cycle(1'b0, 1, 1'b0, 32'h0);
      chk("drop_no_req", 32'(imem_req), 32'd0);
      chk("drop_flushed", 32'(dec_valid), 32'd0);
      wait_xfers(1, 60, "redir_timeout");
      chk("redir_addr", log_at(3), 32'h100);

      // Redirect coinciding with rvalid: no DROP, immediate re-request; also address wrap
      dly_min = 2;
      dly_max = 2;
      wait_grant(40, "e_grant_timeout");
      cycle(1'b0, 1, 1'b0, 32'h0);
      cycle(1'b0, 1, 1'b0, 32'h0);
      cycle(1'b0, 1, 1'b1, 32'hFFFF_FFFE);
      cycle(1'b0, 1, 1'b0, 32'h0);
      chk("same_cycle_req", 32'(imem_req), 32'd1);
      chk("same_cycle_addr", imem_addr, 32'hFFFF_FFFC);
      wait_xfers(2, 60, "wrap_timeout");

      // Reset in the middle of WAIT; the late response must be ignored
      dly_min = 3;
      dly_max = 3;
      wait_grant(40, "f_grant_timeout");
      cycle(1'b1, 1, 1'b0, 32'h0);
      cycle(1'b1, 1, 1'b0, 32'h0);
      cycle(1'b0, 1, 1'b0, 32'h0);
      chk("mid_rst_idle_req", 32'(imem_req), 32'd0);
      chk("mid_rst_valid0", 32'(dec_valid), 32'd0);
      s = gnt_log.size();
      cycle(1'b0, 1, 1'b0, 32'h0);
      chk("mid_rst_req", 32'(imem_req), 32'd1);
      chk("mid_rst_addr", imem_addr, RESET_PC);
      chk("mid_rst_valid1", 32'(dec_valid), 32'd0);
      cycle(1'b0, 1, 1'b0, 32'h0);
      chk("stale_ignored", 32'(dec_valid), 32'd0);
      wait_xfers(1, 40, "post_rst_timeout");
      chk("post_rst_addr", log_at(s), RESET_PC);

      // Randomised traffic against the program-order model
      gnt_pct = 60;
      dly_min = 0;
      dly_max = 3;
      s = n_xfer;
      for (int i = 0; i < 2000; i++) begin
         cycle($urandom_range(299, 0) == 0, int'($urandom_range(9, 0) < 7),
               $urandom_range(29, 0) == 0, $urandom);
      end
      chk("random_progress", 32'((n_xfer - s) > 100), 32'd1);

      // Counters: 3 starved ready cycles, then 5 fetched words consumed without starving
      gnt_pct = 100;
      dly_min = 0;
      dly_max = 0;
      budget  = 0;
      do_reset();
      for (int i = 0; i < 3; i++) cycle(1'b0, 1, 1'b0, 32'h0);
      budget = 5;
      s = n_xfer;
      for (int t = 0; t < 200 && (n_xfer - s) < 5; t++) cycle(1'b0, 2, 1'b0, 32'h0);
      chk("perf_xfers", 32'(n_xfer - s), 32'd5);
      cycle(1'b0, 0, 1'b0, 32'h0);
`ifdef FETCH_PERF_EN
      chk("perf_fetched", perf_fetched, 32'd5);
      chk("perf_stall", perf_stall, 32'd3);
`else
      chk("perf_fetched", perf_fetched, 32'd0);
      chk("perf_stall", perf_stall, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch front end that supplies the decode stage: opcode/funct to the main and ALU control units, plus full instruction and PC.
- Owns the fetch PC and issues word reads to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words in a small FIFO and hands them to decode over valid/ready.
- Handles branch/jump redirects from execute: flushes buffered words and drops any stale response.

Parameters:
DEPTH, 2, FIFO entries (power of 2, >=2)
RESET_PC, 32'h0000_0000, fetch PC after reset

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
imem_req  out  1  read request
imem_addr  out  32  word address of request; [1:0] always 2'b00
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  read data valid
imem_rdata  in  32  read data
redirect  in  1  branch/jump taken
redirect_pc  in  32  new fetch PC
dec_valid  out  1  instruction available to decode
dec_ready  in  1  decode accepts
dec_instr  out  32  head instruction
dec_pc  out  32  PC of head instruction
dec_opcode  out  6  dec_instr[31:26]
dec_funct  out  6  dec_instr[5:0]
perf_fetched  out  32  see Optional Feature
perf_stall  out  32  see Optional Feature

Behaviour:
- One clock: clk. Reset is synchronous and active-high. All state is registered except dec_opcode/dec_funct, which are slices of dec_instr.
- Reset values:
  - fetch_pc = RESET_PC.
  - FIFO empty; dec_valid = 0; imem_req = 0; imem_addr = RESET_PC.
  - State IDLE; perf counters = 0.
  - Reset overrides everything, including redirect, an in-flight request or a pending response.
- Only one memory transaction is outstanding at a time. Response arrives >=1 cycle after gnt. Any imem_rvalid outside WAIT/DROP is ignored.
- Space rule: a request may issue only if count + outstanding < DEPTH. An accepted response therefore never overflows the FIFO.
- FSM states:
  - IDLE:
    - imem_req = 0.
    - If the space rule holds, go to REQ next cycle with imem_addr = fetch_pc.
  - REQ:
    - imem_req = 1. imem_addr is stable until gnt.
    - On gnt: fetch_pc += 4 and go to WAIT.
  - WAIT:
    - On rvalid: push {fetch address, rdata} into the FIFO.
    - Then go to REQ if the space rule still holds (counting this push and any same-cycle pop), else IDLE.
  - DROP:
    - Wait for rvalid and discard the data.
    - Then go to REQ at the redirected fetch_pc.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Decode handshake:
  - dec_valid = FIFO not empty.
  - Transfer occurs when dec_valid && dec_ready; pop takes effect next cycle.
  - dec_instr/dec_pc hold stable while dec_valid && !dec_ready.
  - Push and pop in the same cycle are both honoured.
- Latency: rvalid in cycle N into an empty FIFO gives dec_valid = 1 in cycle N+1. From reset release, imem_req rises in the 2nd clk edge.
- Redirect (registered, takes effect next cycle):
  - FIFO flushed. A transfer in the redirect cycle still counts as consumed.
  - fetch_pc = {redirect_pc[31:2], 2'b00}; misaligned low bits are dropped.
  - IDLE or REQ without gnt: go to REQ with the new address. The ungranted request is withdrawn legally.
  - REQ with gnt in the same cycle: go to DROP.
  - WAIT without rvalid: go to DROP.
  - WAIT with rvalid in the same cycle: data discarded, go to REQ.
  - DROP: stay in DROP; fetch_pc is updated to the newest redirect.
  - Back-to-back redirects: the last one wins.

Optional Feature:
Macro: FETCH_PERF_EN
- Defined:
  - perf_fetched increments on every FIFO push.
  - perf_stall increments every cycle with dec_ready = 1 && dec_valid = 0.
  - Both are 32-bit wrapping, cleared only by reset.
- Not defined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- Reset release, memory with gnt same cycle and rvalid 1 cycle later, dec_ready = 1 -> imem_addr sequence 0x0, 0x4, 0x8; dec_pc 0x0, 0x4, 0x8 in order. For rdata 32'h0000_0020 (add): dec_opcode = 6'h00, dec_funct = 6'h20.
- dec_ready = 0 for 10 cycles, DEPTH = 2 -> exactly 2 pushes. imem_req stays 0 while full. dec_instr holds the word from 0x0 unchanged. Raising dec_ready drains 0x0 then 0x4, then fetch resumes at 0x8.
- redirect = 1, redirect_pc = 32'h0000_0103 while in WAIT for 0x8 -> response for 0x8 dropped; FIFO flushed; next imem_addr = 0x100; next dec_pc = 0x100.
- redirect in the same cycle as rvalid -> no DROP state; next request at the redirect address the following cycle; discarded data never appears at decode.
- reset = 1 mid-WAIT, then rvalid arrives -> response ignored; dec_valid = 0; first request to RESET_PC. With RESET_PC = 32'hFFFF_FFFC: second address is 0x0.
- With FETCH_PERF_EN and 5 fetched words plus 3 starved ready cycles -> perf_fetched = 5, perf_stall = 3. Without the macro, both read 0.
